// File: rtl/msg_uart_tx.sv
// Serializes a 16-character message buffer onto a UART TX line, oldest byte first, LSB first (8N1).
// Define MSG_UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module msg_uart_tx #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int NUM_BYTES    = 16,
    localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
    localparam int BAUD_W = $clog2(CLKS_PER_BIT)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [8*NUM_BYTES-1:0] msg_in,
    input  logic                   send,
    input  logic                   abort,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       byte_idx
);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MSG_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [2:0]             bit_cnt;
    logic [8*NUM_BYTES-1:0] shift_reg;
    logic [7:0]             cur_byte;
    logic [2:0]             next_bit;
    logic                   baud_wrap;

    // The byte on the line always sits in the top 8 bits; the register shifts left one byte per frame.
    assign cur_byte  = shift_reg[8*NUM_BYTES-1 -: 8];
    assign next_bit  = bit_cnt + 3'd1;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            byte_idx  <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            end

            if (state != IDLE && abort) begin
                state    <= IDLE;
                tx       <= 1'b1;
                busy     <= 1'b0;
                byte_idx <= '0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // abort has priority over send even when idle
                        if (send && !abort) begin
                            shift_reg <= msg_in;
                            state     <= START;
                            tx        <= 1'b0;
                            busy      <= 1'b1;
                            baud_cnt  <= '0;
                            bit_cnt   <= '0;
                            byte_idx  <= '0;
                        end
                    end
                    START: begin
                        if (baud_wrap) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            tx      <= cur_byte[0];
                        end
                    end
                    DATA: begin
                        if (baud_wrap) begin
                            if (bit_cnt == 3'd7) begin
`ifdef MSG_UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= ^cur_byte;
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= next_bit;
                                tx      <= cur_byte[next_bit];
                            end
                        end
                    end
`ifdef MSG_UART_TX_PARITY_EN
                    PARITY: begin
                        if (baud_wrap) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (baud_wrap) begin
                            if (byte_idx != IDX_LAST) begin
                                byte_idx  <= byte_idx + 1'b1;
                                shift_reg <= shift_reg << 8;
                                state     <= START;
                                tx        <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                tx       <= 1'b1;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                byte_idx <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
